// File: rtl/vpifo_pkg.sv
// vpifo_pkg: shared default widths, push request record and grant encoding for the vPIFO ingress path
package vpifo_pkg;
    localparam int PKG_PTW       = 16;
    localparam int PKG_MTW       = 2;
    localparam int PKG_LEVEL     = 4;
    localparam int PKG_TREE_NUM  = 4;
    localparam int TREE_NUM_BITS = $clog2(PKG_TREE_NUM);
    localparam int LEVEL_BITS    = $clog2(PKG_LEVEL);
    localparam int ROOT_TREE_ID  = 0;

    typedef struct packed {
        logic [TREE_NUM_BITS-1:0]   tree_id;
        logic [PKG_PTW-1:0]         prio;
        logic [PKG_MTW+PKG_PTW-1:0] data;
    } push_req_t;

    typedef enum logic {GNT_PUSH, GNT_POP} grant_e;
endpackage

// File: rtl/vpifo_req_fifo.sv
// vpifo_req_fifo: circular buffer of push requests; ready is derived only from the count register
module vpifo_req_fifo
    import vpifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      wr_en,
    input  push_req_t wr_data,
    input  logic      rd_en,
    output push_req_t rd_data,
    output logic      ready,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    push_req_t     mem [DEPTH];

    assign rd_data = mem[rd_ptr];
    assign empty   = count == '0;
    assign ready   = count < (AW+1)'(DEPTH);

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/vpifo_ingress_arbiter.sv
// vpifo_ingress_arbiter: buffers pushes, holds pending pops and issues at most one
// push or pop per cycle to the task generator, tracking root-tree occupancy.
module vpifo_ingress_arbiter
    import vpifo_pkg::*;
#(
    parameter int PTW       = PKG_PTW,
    parameter int MTW       = PKG_MTW,
    parameter int LEVEL     = PKG_LEVEL,
    parameter int TREE_NUM  = PKG_TREE_NUM,
    parameter int REQ_DEPTH = 4,
    parameter int CAPACITY  = 256,
    parameter int POP_W     = 4,
    localparam int TNB      = $clog2(TREE_NUM),
    localparam int OCC_W    = $clog2(CAPACITY + 1)
) (
    input  logic               i_clk,
    input  logic               i_arst,
    input  logic               i_push_valid,
    output logic               o_push_ready,
    input  logic [TNB-1:0]     i_push_tree_id,
    input  logic [PTW-1:0]     i_push_priority,
    input  logic [MTW+PTW-1:0] i_push_data,
    input  logic               i_pop_req,
    output logic               o_push,
    output logic [TNB-1:0]     o_push_tree_id,
    output logic [PTW-1:0]     o_push_priority,
    output logic [MTW+PTW-1:0] o_push_data,
    output logic               o_pop,
    input  logic               i_task_fifo_full,
    output logic [OCC_W-1:0]   o_occupancy,
    output logic [POP_W-1:0]   o_pop_pending,
    output logic               o_err_bad_tree,
    output logic               o_err_pop_ovf
);
    localparam int LB = $clog2(LEVEL);
    localparam logic [TNB-1:0]   LVL_MASK = TNB'((1 << LB) - 1);
    localparam logic [POP_W-1:0] POP_MAX  = '1;

    push_req_t head;
    push_req_t wr_req;
    grant_e    last_grant;
    logic      fifo_ready;
    logic      empty;
    logic      head_ok;
    logic      push_ok;
    logic      pop_ok;
    logic      gnt_push;
    logic      gnt_pop;
    logic      drop_bad;
    logic      pop_inc;

    assign wr_req       = '{tree_id: i_push_tree_id, prio: i_push_priority, data: i_push_data};
    assign o_push_ready = fifo_ready;

    vpifo_req_fifo #(.DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk     (i_clk),
        .rst     (i_arst),
        .wr_en   (i_push_valid && fifo_ready),
        .wr_data (wr_req),
        .rd_en   (gnt_push || drop_bad),
        .rd_data (head),
        .ready   (fifo_ready),
        .empty   (empty)
    );

    // Ties alternate against the last grant; a saturated pending counter still
    // accepts a request when a pop issues in the same cycle.
    always_comb begin
        head_ok  = (head.tree_id & LVL_MASK) != TNB'(ROOT_TREE_ID);
        drop_bad = !empty && !head_ok;
        push_ok  = !empty && head_ok && !i_task_fifo_full && o_occupancy < OCC_W'(CAPACITY);
        pop_ok   = o_pop_pending != '0 && o_occupancy != '0;
        gnt_push = push_ok && (!pop_ok || last_grant == GNT_POP);
        gnt_pop  = pop_ok && !gnt_push;
        pop_inc  = i_pop_req && (o_pop_pending != POP_MAX || gnt_pop);
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_push          <= 1'b0;
            o_pop           <= 1'b0;
            o_push_tree_id  <= '0;
            o_push_priority <= '0;
            o_push_data     <= '0;
            o_occupancy     <= '0;
            o_pop_pending   <= '0;
            o_err_bad_tree  <= 1'b0;
            o_err_pop_ovf   <= 1'b0;
            last_grant      <= GNT_POP;
        end else begin
            o_push <= gnt_push;
            o_pop  <= gnt_pop;
            if (gnt_push) begin
                o_push_tree_id  <= head.tree_id;
                o_push_priority <= head.prio;
                o_push_data     <= head.data;
            end
            if (gnt_push || gnt_pop) last_grant <= gnt_push ? GNT_PUSH : GNT_POP;
            o_occupancy   <= o_occupancy + OCC_W'(gnt_push) - OCC_W'(gnt_pop);
            o_pop_pending <= o_pop_pending + POP_W'(pop_inc) - POP_W'(gnt_pop);
            if (drop_bad) o_err_bad_tree <= 1'b1;
            if (i_pop_req && !pop_inc) o_err_pop_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vpifo_ingress_arbiter.sv
// tb_vpifo_ingress_arbiter: directed checks of buffering, filtering, pop holding and grant alternation
module tb_vpifo_ingress_arbiter;
    logic        i_clk = 1'b0;
    logic        i_arst;
    logic        i_push_valid;
    logic        o_push_ready;
    logic [1:0]  i_push_tree_id;
    logic [15:0] i_push_priority;
    logic [17:0] i_push_data;
    logic        i_pop_req;
    logic        o_push;
    logic [1:0]  o_push_tree_id;
    logic [15:0] o_push_priority;
    logic [17:0] o_push_data;
    logic        o_pop;
    logic        i_task_fifo_full;
    logic [8:0]  o_occupancy;
    logic [3:0]  o_pop_pending;
    logic        o_err_bad_tree;
    logic        o_err_pop_ovf;

    int total = 0;
    int fails = 0;

    vpifo_ingress_arbiter dut (
        .i_clk            (i_clk),
        .i_arst           (i_arst),
        .i_push_valid     (i_push_valid),
        .o_push_ready     (o_push_ready),
        .i_push_tree_id   (i_push_tree_id),
        .i_push_priority  (i_push_priority),
        .i_push_data      (i_push_data),
        .i_pop_req        (i_pop_req),
        .o_push           (o_push),
        .o_push_tree_id   (o_push_tree_id),
        .o_push_priority  (o_push_priority),
        .o_push_data      (o_push_data),
        .o_pop            (o_pop),
        .i_task_fifo_full (i_task_fifo_full),
        .o_occupancy      (o_occupancy),
        .o_pop_pending    (o_pop_pending),
        .o_err_bad_tree   (o_err_bad_tree),
        .o_err_pop_ovf    (o_err_pop_ovf)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        i_arst = 1'b1;
        i_push_valid = 1'b0;
        i_pop_req = 1'b0;
        tick();
        i_arst = 1'b0;
    endtask

    task automatic set_push(input logic v, input logic [1:0] t, input logic [15:0] p, input logic [17:0] d);
        i_push_valid = v;
        i_push_tree_id = t;
        i_push_priority = p;
        i_push_data = d;
    endtask

    initial begin
        i_task_fifo_full = 1'b0;
        set_push(1'b0, 2'd0, 16'h0, 18'h0);
        do_reset();

        // reset in the middle of queued traffic
        i_task_fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, 2'd1, 16'h700 + 16'(i), 18'h3_0000 + 18'(i));
            tick();
        end
        set_push(1'b0, 2'd1, 16'h0, 18'h0);
        i_arst = 1'b1;
        tick();
        chk("rst_push", 32'(o_push), 32'd0);
        chk("rst_pop", 32'(o_pop), 32'd0);
        chk("rst_ready", 32'(o_push_ready), 32'd1);
        chk("rst_occ", 32'(o_occupancy), 32'd0);
        chk("rst_pend", 32'(o_pop_pending), 32'd0);
        chk("rst_fields", {12'(0), o_push_tree_id, o_push_priority, 2'(o_push_data >> 16)}, 32'd0);
        chk("rst_errs", {30'(0), o_err_bad_tree, o_err_pop_ovf}, 32'd0);
        i_arst = 1'b0;
        tick();
        chk("rst_idle_push", 32'(o_push), 32'd0);

        // fill the request FIFO while the generator is full
        for (int i = 0; i < 4; i++) begin
            set_push(1'b1, 2'd1, 16'h10 + 16'(i), 18'h2_0000 + 18'(i));
            tick();
            chk($sformatf("fill_ready%0d", i), 32'(o_push_ready), (i < 3) ? 32'd1 : 32'd0);
        end
        set_push(1'b0, 2'd0, 16'h0, 18'h0);
        tick();
        chk("fill_nopush", 32'(o_push), 32'd0);
        chk("fill_occ", 32'(o_occupancy), 32'd0);
        i_task_fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("drain_push%0d", i), 32'(o_push), 32'd1);
            chk($sformatf("drain_prio%0d", i), 32'(o_push_priority), 32'h10 + 32'(i));
            chk($sformatf("drain_data%0d", i), 32'(o_push_data), 32'h2_0000 + 32'(i));
            chk($sformatf("drain_occ%0d", i), 32'(o_occupancy), 32'(i + 1));
        end
        tick();
        chk("drain_end_push", 32'(o_push), 32'd0);
        chk("drain_hold_prio", 32'(o_push_priority), 32'h13);
        chk("drain_ready", 32'(o_push_ready), 32'd1);

        // root tree id is dropped, the following push is delayed one cycle
        set_push(1'b1, 2'd0, 16'hbad, 18'h0_0bad);
        tick();
        chk("bad_err_before", 32'(o_err_bad_tree), 32'd0);
        set_push(1'b1, 2'd2, 16'h22, 18'h1_2222);
        tick();
        set_push(1'b0, 2'd0, 16'h0, 18'h0);
        chk("bad_err", 32'(o_err_bad_tree), 32'd1);
        chk("bad_nopush", 32'(o_push), 32'd0);
        tick();
        chk("t2_push", 32'(o_push), 32'd1);
        chk("t2_tree", 32'(o_push_tree_id), 32'd2);
        chk("t2_prio", 32'(o_push_priority), 32'h22);
        chk("t2_occ", 32'(o_occupancy), 32'd5);
        tick();
        chk("t2_end", 32'(o_push), 32'd0);
        chk("t2_hold_tree", 32'(o_push_tree_id), 32'd2);

        // pops held on an empty root
        do_reset();
        chk("rst2_err", 32'(o_err_bad_tree), 32'd0);
        i_pop_req = 1'b1;
        tick();
        tick();
        i_pop_req = 1'b0;
        chk("hold_pend", 32'(o_pop_pending), 32'd2);
        tick();
        chk("hold_nopop", 32'(o_pop), 32'd0);
        chk("hold_pend2", 32'(o_pop_pending), 32'd2);
        set_push(1'b1, 2'd3, 16'h33, 18'h3_3333);
        tick();
        set_push(1'b0, 2'd0, 16'h0, 18'h0);
        chk("hp_nopush", 32'(o_push), 32'd0);
        tick();
        chk("hp_push", 32'(o_push), 32'd1);
        chk("hp_tree", 32'(o_push_tree_id), 32'd3);
        chk("hp_occ1", 32'(o_occupancy), 32'd1);
        chk("hp_nopop", 32'(o_pop), 32'd0);
        tick();
        chk("hp_pop", 32'(o_pop), 32'd1);
        chk("hp_pop_nopush", 32'(o_push), 32'd0);
        chk("hp_occ0", 32'(o_occupancy), 32'd0);
        chk("hp_pend1", 32'(o_pop_pending), 32'd1);
        tick();
        chk("hp_pop_end", 32'(o_pop), 32'd0);
        chk("hp_pend_keep", 32'(o_pop_pending), 32'd1);

        // alternation when both push and pop are eligible
        i_task_fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_push(1'b1, 2'd1, 16'h50 + 16'(i), 18'h0_0050 + 18'(i));
            i_pop_req = (i < 3);
            tick();
        end
        set_push(1'b0, 2'd0, 16'h0, 18'h0);
        i_pop_req = 1'b0;
        chk("alt_pend", 32'(o_pop_pending), 32'd4);
        chk("alt_idle", {30'(0), o_push, o_pop}, 32'd0);
        i_task_fifo_full = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("alt%0d", k), {30'(0), o_push, o_pop}, (k % 2 == 1) ? 32'd2 : 32'd1);
            if (k % 2 == 1) chk($sformatf("alt_prio%0d", k), 32'(o_push_priority), 32'h50 + 32'(k / 2));
        end
        chk("alt_occ", 32'(o_occupancy), 32'd0);
        chk("alt_pend_end", 32'(o_pop_pending), 32'd1);

        // pending counter saturation
        do_reset();
        i_pop_req = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) begin
                chk("ovf_pend15", 32'(o_pop_pending), 32'd15);
                chk("ovf_not_yet", 32'(o_err_pop_ovf), 32'd0);
            end
        end
        i_pop_req = 1'b0;
        chk("ovf_pend", 32'(o_pop_pending), 32'd15);
        chk("ovf_flag", 32'(o_err_pop_ovf), 32'd1);
        tick();
        chk("ovf_sticky", 32'(o_err_pop_ovf), 32'd1);
        chk("ovf_nopop", 32'(o_pop), 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
